// File: rtl/la_wave_render.sv
// VGA display stage for the logic-analyser capture: 640x480@60 timing, capture RAM
// addressing and rendering of 8 channels as stacked square-wave traces.
module la_wave_render #(
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYN  = 96,
    parameter int H_BP   = 48,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYN  = 2,
    parameter int V_BP   = 33,
    parameter int N_SMP  = 43,
    parameter int CELL_W = 14,
    parameter int CH_H   = 48,
    parameter int X0     = 19,
    parameter int Y0     = 48,
    parameter int RD_LAT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ram_flag_one,
    input  logic [7:0] q_sig,
    output logic [5:0] vga_addr,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [7:0] vga_rgb
);

    localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;

    localparam logic [9:0] H_END    = 10'(H_TOT - 1);
    localparam logic [9:0] V_END    = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT_L  = 10'(H_ACT);
    localparam logic [9:0] V_ACT_L  = 10'(V_ACT);
    localparam logic [9:0] HS_BEG   = 10'(H_ACT + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACT + H_FP + H_SYN);
    localparam logic [9:0] VS_BEG   = 10'(V_ACT + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACT + V_FP + V_SYN);
    localparam logic [9:0] X_BEG    = 10'(X0);
    localparam logic [9:0] X_END    = 10'(X0 + N_SMP * CELL_W);
    localparam logic [9:0] Y_BEG    = 10'(Y0);
    localparam logic [9:0] Y_END    = 10'(Y0 + 8 * CH_H);
    localparam logic [3:0] SUB_LAST = 4'(CELL_W - 1);
    localparam logic [5:0] ROW_LAST = 6'(CH_H - 1);
    localparam logic [5:0] ROW_HI   = 6'd8;
    localparam logic [5:0] ROW_LO   = 6'(CH_H - 8);

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       plot;
        logic       sub0;
        logic       col0;
        logic [2:0] band;
        logic [5:0] row;
    } pix_t;

    // Syncs reset to their inactive level so no spurious pulse leaves the pipe.
    localparam pix_t PIX_RST = '{hs: 1'b1, vs: 1'b1, default: '0};

    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [5:0] row_q, row_d;
    logic [2:0] band_q, band_d;
    logic [3:0] sub_q, sub_d;
    logic [5:0] addr_q, addr_d;
    logic       disp_ok_q;
    logic       in_x, in_y;
    pix_t       st_d;
    pix_t       st_q [RD_LAT+1];
    pix_t       s_end;
    logic [7:0] last_q;
    logic       hs_q, vs_q;
    logic [7:0] rgb_q, rgb_d;
    logic       bit_cur, bit_prev;

    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        row_d  = row_q;
        band_d = band_q;
        if (hcnt_q == H_END) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_END) ? '0 : vcnt_q + 10'd1;
            if (vcnt_d == Y_BEG) begin
                row_d  = '0;
                band_d = '0;
            end else if (row_q == ROW_LAST) begin
                row_d  = '0;
                band_d = band_q + 3'd1;
            end else begin
                row_d  = row_q + 6'd1;
            end
        end
    end

    assign in_x = (hcnt_q >= X_BEG) && (hcnt_q < X_END);
    assign in_y = (vcnt_q >= Y_BEG) && (vcnt_q < Y_END);

    // Column address tracks hcnt with a sub-cell counter instead of a divider.
    always_comb begin
        sub_d  = '0;
        addr_d = '0;
        if (in_x && (hcnt_q != X_BEG)) begin
            if (sub_q == SUB_LAST) begin
                addr_d = addr_q + 6'd1;
            end else begin
                sub_d  = sub_q + 4'd1;
                addr_d = addr_q;
            end
        end
    end

    always_comb begin
        st_d      = PIX_RST;
        st_d.hs   = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
        st_d.vs   = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
        st_d.act  = (hcnt_q < H_ACT_L) && (vcnt_q < V_ACT_L);
        st_d.plot = in_x && in_y;
        st_d.sub0 = in_x && (sub_d == 4'd0);
        st_d.col0 = (addr_d == 6'd0);
        st_d.band = band_q;
        st_d.row  = row_q;
    end

    assign s_end    = st_q[RD_LAT];
    assign bit_cur  = q_sig[s_end.band];
    assign bit_prev = last_q[s_end.band];

    always_comb begin
        rgb_d = 8'h00;
        if (s_end.act && s_end.plot) begin
            if (s_end.row == 6'd0)
                rgb_d = 8'h49;
            else if (!disp_ok_q)
                rgb_d = 8'h00;
            else if (s_end.col0 && (s_end.row == ROW_LAST))
                rgb_d = 8'hE0;
            else if ((bit_cur && (s_end.row == ROW_HI)) || (!bit_cur && (s_end.row == ROW_LO)))
                rgb_d = 8'h1C;
            else if (s_end.sub0 && !s_end.col0 && (bit_cur != bit_prev) &&
                     (s_end.row >= ROW_HI) && (s_end.row <= ROW_LO))
                rgb_d = 8'h1C;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            row_q     <= '0;
            band_q    <= '0;
            sub_q     <= '0;
            addr_q    <= '0;
            disp_ok_q <= 1'b0;
            for (int i = 0; i <= RD_LAT; i++) st_q[i] <= PIX_RST;
            last_q    <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            rgb_q     <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            row_q  <= row_d;
            band_q <= band_d;
            sub_q  <= sub_d;
            addr_q <= addr_d;
            // Frame freeze: the record is accepted only at the start of vertical blanking.
            if ((hcnt_q == 10'd0) && (vcnt_q == V_ACT_L))
                disp_ok_q <= ram_flag_one;
            st_q[0] <= st_d;
            for (int i = 1; i <= RD_LAT; i++) st_q[i] <= st_q[i-1];
            last_q <= q_sig;
            hs_q   <= s_end.hs;
            vs_q   <= s_end.vs;
            rgb_q  <= rgb_d;
        end
    end

    assign vga_addr = addr_q;
    assign vga_hs   = hs_q;
    assign vga_vs   = vs_q;
    assign vga_rgb  = rgb_q;

endmodule

// File: tb/tb_la_wave_render.sv
// Directed bench for la_wave_render on a shrunken raster (48x160 clocks per frame)
// so several whole frames fit in a short run; expected pixels are hand-derived.
module tb_la_wave_render;

    localparam int HT    = 48;
    localparam int VT    = 160;
    localparam int FRAME = HT * VT;
    localparam int PLAT  = 5;
    localparam int ALAT  = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ram_flag_one = 1'b0;
    logic [7:0] q_sig = 8'h00;
    logic [5:0] vga_addr;
    logic       vga_hs, vga_vs;
    logic [7:0] vga_rgb;

    logic [7:0] mem [0:7];
    logic [7:0] rd1 = 8'h00, rd2 = 8'h00;
    int         cyc;
    int         errors = 0;
    int         checks = 0;

    la_wave_render #(
        .H_ACT(36), .H_FP(4), .H_SYN(4), .H_BP(4),
        .V_ACT(150), .V_FP(3), .V_SYN(2), .V_BP(5),
        .N_SMP(8), .CELL_W(4), .CH_H(18), .X0(3), .Y0(4), .RD_LAT(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ram_flag_one(ram_flag_one), .q_sig(q_sig),
        .vga_addr(vga_addr), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb)
    );

    always #5 clk = ~clk;

    // Capture RAM with three cycles of read latency.
    always @(posedge clk) begin
        rd1   <= (vga_addr < 6'd8) ? mem[vga_addr[2:0]] : 8'h00;
        rd2   <= rd1;
        q_sig <= rd2;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic set_mem(input logic [7:0] v);
        for (int i = 0; i < 8; i++) mem[i] = v;
    endtask

    // Advance (on falling edges) to the next time raster point (x,y) is at the pins.
    task automatic wait_pix(input int x, input int y, input int lat);
        int target, guard;
        target = y * HT + x + lat;
        while (target <= cyc) target += FRAME;
        guard = 0;
        while (cyc != target && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != target) begin
            checks++; errors++;
            $display("FAIL wait_pix (%0d,%0d) timeout cyc=%0d target=%0d", x, y, cyc, target);
        end
    endtask

    task automatic test_reset();
        int hs_f0 = -1, hs_f1 = -1, hs_r0 = -1, vs_f0 = -1, vs_f1 = -1, vs_r0 = -1;
        int blank_bad = 0, p, h, v;
        logic hs_p = 1'b1, vs_p = 1'b1;
        rst_n = 1'b0; ram_flag_one = 1'b0; set_mem(8'hFF);
        repeat (3) @(negedge clk);
        checks++; if (vga_hs !== 1'b1) begin errors++; $display("FAIL reset_hs got=%b exp=1", vga_hs); end
        checks++; if (vga_vs !== 1'b1) begin errors++; $display("FAIL reset_vs got=%b exp=1", vga_vs); end
        checks++; if (vga_rgb !== 8'h00) begin errors++; $display("FAIL reset_rgb got=%h exp=00", vga_rgb); end
        checks++; if (vga_addr !== 6'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", vga_addr); end
        rst_n = 1'b1;
        for (int i = 0; i < 15200; i++) begin
            @(negedge clk);
            if (hs_p && !vga_hs) begin
                if (hs_f0 < 0) hs_f0 = cyc; else if (hs_f1 < 0) hs_f1 = cyc;
            end
            if (!hs_p && vga_hs && hs_r0 < 0) hs_r0 = cyc;
            if (vs_p && !vga_vs) begin
                if (vs_f0 < 0) vs_f0 = cyc; else if (vs_f1 < 0) vs_f1 = cyc;
            end
            if (!vs_p && vga_vs && vs_r0 < 0) vs_r0 = cyc;
            hs_p = vga_hs; vs_p = vga_vs;
            if (cyc < PLAT) begin
                if (vga_rgb !== 8'h00) blank_bad++;
            end else begin
                p = cyc - PLAT; h = p % HT; v = (p / HT) % VT;
                if ((h >= 36 || v >= 150) && vga_rgb !== 8'h00) blank_bad++;
            end
        end
        checks++; if (hs_f0 !== 45) begin errors++; $display("FAIL hs_first_low got=%0d exp=45", hs_f0); end
        checks++; if (hs_f1 - hs_f0 !== 48) begin errors++; $display("FAIL hs_period got=%0d exp=48", hs_f1 - hs_f0); end
        checks++; if (hs_r0 - hs_f0 !== 4) begin errors++; $display("FAIL hs_width got=%0d exp=4", hs_r0 - hs_f0); end
        checks++; if (vs_f0 !== 7349) begin errors++; $display("FAIL vs_first_low got=%0d exp=7349", vs_f0); end
        checks++; if (vs_f1 - vs_f0 !== 7680) begin errors++; $display("FAIL vs_period got=%0d exp=7680", vs_f1 - vs_f0); end
        checks++; if (vs_r0 - vs_f0 !== 96) begin errors++; $display("FAIL vs_width got=%0d exp=96", vs_r0 - vs_f0); end
        checks++; if (blank_bad !== 0) begin errors++; $display("FAIL blank_rgb nonzero_count=%0d exp=0", blank_bad); end
    endtask

    task automatic test_grid();
        int         xs [9] = '{2, 3, 34, 35, 10, 10, 5, 3, 10};
        int         ys [9] = '{4, 4, 4, 4, 12, 14, 21, 130, 148};
        logic [7:0] ex [9] = '{8'h00, 8'h49, 8'h49, 8'h00, 8'h00, 8'h00, 8'h00, 8'h49, 8'h00};
        for (int i = 0; i < 9; i++) begin
            wait_pix(xs[i], ys[i], PLAT);
            checks++;
            if (vga_rgb !== ex[i]) begin
                errors++;
                $display("FAIL grid (%0d,%0d) rgb=%h exp=%h", xs[i], ys[i], vga_rgb, ex[i]);
            end
        end
        ram_flag_one = 1'b1;
        set_mem(8'h00);
    endtask

    task automatic test_zero();
        int         xs [12] = '{3, 3, 3, 34, 35, 3, 6, 7, 3, 20, 34, 3};
        int         ys [12] = '{4, 12, 14, 14, 14, 21, 21, 21, 22, 32, 140, 147};
        logic [7:0] ex [12] = '{8'h49, 8'h00, 8'h1C, 8'h1C, 8'h00, 8'hE0, 8'hE0, 8'h00,
                                8'h49, 8'h1C, 8'h1C, 8'hE0};
        for (int i = 0; i < 12; i++) begin
            wait_pix(xs[i], ys[i], PLAT);
            checks++;
            if (vga_rgb !== ex[i]) begin
                errors++;
                $display("FAIL zero (%0d,%0d) rgb=%h exp=%h", xs[i], ys[i], vga_rgb, ex[i]);
            end
        end
    endtask

    task automatic test_edge();
        int         xs [16] = '{11, 10, 11, 14, 15, 16, 11, 12, 15, 10, 11, 12, 15, 16, 11, 11};
        int         ys [16] = '{11, 12, 12, 12, 12, 12, 13, 13, 13, 14, 14, 14, 14, 14, 31, 32};
        logic [7:0] ex [16] = '{8'h00, 8'h00, 8'h1C, 8'h1C, 8'h1C, 8'h00, 8'h1C, 8'h00,
                                8'h1C, 8'h1C, 8'h1C, 8'h00, 8'h1C, 8'h1C, 8'h00, 8'h1C};
        wait_pix(0, 149, PLAT);
        mem[2] = 8'h01;
        for (int i = 0; i < 16; i++) begin
            wait_pix(xs[i], ys[i], PLAT);
            checks++;
            if (vga_rgb !== ex[i]) begin
                errors++;
                $display("FAIL edge (%0d,%0d) rgb=%h exp=%h", xs[i], ys[i], vga_rgb, ex[i]);
            end
        end
    endtask

    task automatic test_addr();
        int         hs [8] = '{2, 3, 6, 7, 10, 11, 34, 35};
        logic [5:0] ex [8] = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd2, 6'd7, 6'd0};
        for (int i = 0; i < 8; i++) begin
            wait_pix(hs[i], 50, ALAT);
            checks++;
            if (vga_addr !== ex[i]) begin
                errors++;
                $display("FAIL addr hcnt=%0d got=%0d exp=%0d", hs[i], vga_addr, ex[i]);
            end
        end
    endtask

    task automatic test_drop();
        int         xs [4] = '{3, 20, 3, 11};
        int         ys [4] = '{4, 14, 21, 12};
        logic [7:0] ex [4] = '{8'h49, 8'h00, 8'h00, 8'h00};
        wait_pix(0, 0, PLAT);
        wait_pix(3, 14, PLAT);
        checks++; if (vga_rgb !== 8'h1C) begin errors++; $display("FAIL drop_pre rgb=%h exp=1c", vga_rgb); end
        wait_pix(0, 100, PLAT);
        ram_flag_one = 1'b0;
        wait_pix(20, 104, PLAT);
        checks++; if (vga_rgb !== 8'h1C) begin errors++; $display("FAIL drop_same_frame rgb=%h exp=1c", vga_rgb); end
        wait_pix(0, 0, PLAT);
        for (int i = 0; i < 4; i++) begin
            wait_pix(xs[i], ys[i], PLAT);
            checks++;
            if (vga_rgb !== ex[i]) begin
                errors++;
                $display("FAIL drop_next (%0d,%0d) rgb=%h exp=%h", xs[i], ys[i], vga_rgb, ex[i]);
            end
        end
    endtask

    task automatic test_midreset();
        int hs_low = -1;
        wait_pix(20, 94, PLAT);
        checks++; if (vga_rgb !== 8'h49) begin errors++; $display("FAIL mid_pre_rgb got=%h exp=49", vga_rgb); end
        checks++; if (vga_addr !== 6'd5) begin errors++; $display("FAIL mid_pre_addr got=%0d exp=5", vga_addr); end
        rst_n = 1'b0;
        #1;
        checks++; if (vga_rgb !== 8'h00) begin errors++; $display("FAIL mid_rgb got=%h exp=00", vga_rgb); end
        checks++; if (vga_addr !== 6'd0) begin errors++; $display("FAIL mid_addr got=%0d exp=0", vga_addr); end
        checks++; if (vga_hs !== 1'b1) begin errors++; $display("FAIL mid_hs got=%b exp=1", vga_hs); end
        checks++; if (vga_vs !== 1'b1) begin errors++; $display("FAIL mid_vs got=%b exp=1", vga_vs); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200 && hs_low < 0; i++) begin
            @(negedge clk);
            if (!vga_hs) hs_low = cyc;
        end
        checks++; if (hs_low !== 45) begin errors++; $display("FAIL mid_first_hs got=%0d exp=45", hs_low); end
    endtask

    initial begin
        test_reset();
        test_grid();
        test_zero();
        test_edge();
        test_addr();
        test_drop();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
